arm_sequencer: RTL and testbench

- Multi-cycle control sequencer for the 16-bit Harvard core; it is the controlling end of the ALU interface.
- Fetches 16-bit instructions from instruction memory, latches them, and drives the ALU's 5-bit inst field, one-hot state vector and register-file selects.
- Tracks ALU write-backs to keep a zero flag, and resolves branches and halt.
- Sits between instruction memory, register file and ALU.

---
 rtl/arm_sequencer_if.sv | 38 +++
 rtl/arm_sequencer.sv | 142 ++++++++++++++
 tb/tb_arm_sequencer.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/arm_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : arm_sequencer_if
// Description : Bus bundle between the control sequencer, instruction memory,
//               register file and ALU. The sequencer is the controlling
//               (master) end; the datapath side uses the slave modport.
// Revision    : 1.0 - initial release
// ============================================================================
interface arm_sequencer_if #(
   parameter int PC_WIDTH = 8
);
   // Datapath to sequencer
   logic                run;
   logic [15:0]         imem_data;
   logic                alu_wen;
   logic [15:0]         alu_d_out;

   // Sequencer to datapath
   logic [PC_WIDTH-1:0] imem_addr;
   logic [4:0]          inst;
   logic [3:0]          state;
   logic [2:0]          rd_sel;
   logic [2:0]          rs_sel;
   logic                mul_start;
   logic                zero;
   logic                halted;

   modport master (
      input  run, imem_data, alu_wen, alu_d_out,
      output imem_addr, inst, state, rd_sel, rs_sel, mul_start, zero, halted
   );

   modport slave (
      output run, imem_data, alu_wen, alu_d_out,
      input  imem_addr, inst, state, rd_sel, rs_sel, mul_start, zero, halted
   );
endinterface
`default_nettype wire

// File: rtl/arm_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : arm_sequencer
// Description : Multi-cycle control sequencer for the 16-bit Harvard core.
//               Fetches and latches instructions, walks the one-hot
//               FETCH/EXEC1/EXEC2/EXEC3 sequence, keeps the zero flag from
//               ALU write-backs and resolves branches and halt.
// Revision    : 1.0 - initial release
// ============================================================================
module arm_sequencer #(
   parameter int                  PC_WIDTH = 8,
   parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
   input  wire logic       clk,
   input  wire logic       reset_n,
   arm_sequencer_if.master bus
);

   // One-hot execution phases; all-zero is the terminal HALT state
   typedef enum logic [3:0] {
      ST_HALT  = 4'b0000,
      ST_FETCH = 4'b0001,
      ST_EXEC1 = 4'b0010,
      ST_EXEC2 = 4'b0100,
      ST_EXEC3 = 4'b1000
   } state_t;

   localparam logic [4:0] c_op_b    = 5'b00001;
   localparam logic [4:0] c_op_bz   = 5'b00010;
   localparam logic [4:0] c_op_halt = 5'b00011;

   state_t              r_state;
   logic [PC_WIDTH-1:0] r_pc;
   logic [15:0]         r_ir;
   logic                r_zero;
   logic                r_halted;

   logic [4:0]          w_opcode;
   logic                w_is_ldr;
   logic                w_is_mul;
   logic                w_is_b;
   logic                w_is_bz;
   logic                w_is_halt;
   logic                w_take_branch;
   logic [PC_WIDTH-1:0] w_imm_ext;
   logic [PC_WIDTH-1:0] w_pc_inc;
   logic [PC_WIDTH-1:0] w_br_target;

   // Decode from the latched instruction so it is stable for every execute cycle
   assign w_opcode  = r_ir[15:11];
   assign w_is_ldr  = (w_opcode[4:1] == 4'b1110);
   assign w_is_mul  = (w_opcode[4:1] == 4'b1101);
   assign w_is_b    = (w_opcode == c_op_b);
   assign w_is_bz   = (w_opcode == c_op_bz);
   assign w_is_halt = (w_opcode == c_op_halt);

   // bz looks at the flag as registered, before any same-edge write-back
   assign w_take_branch = w_is_b | (w_is_bz & r_zero);

   // Sign-extend (or truncate) the 8-bit branch offset to the PC width
   generate
      if (PC_WIDTH > 8) begin : g_sext_wide
         assign w_imm_ext = {{(PC_WIDTH-8){r_ir[7]}}, r_ir[7:0]};
      end else if (PC_WIDTH == 8) begin : g_sext_exact
         assign w_imm_ext = r_ir[7:0];
      end else begin : g_sext_narrow
         assign w_imm_ext = r_ir[PC_WIDTH-1:0];
      end
   endgenerate

   // Both adders wrap naturally modulo 2^PC_WIDTH
   assign w_pc_inc    = r_pc + 1'b1;
   assign w_br_target = r_pc + w_imm_ext;

   // Sequencer state, program counter and instruction register
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_state  <= ST_FETCH;
         r_pc     <= RESET_PC;
         r_ir     <= '0;
         r_halted <= 1'b0;
      end else begin
         case (r_state)
            ST_FETCH: begin
               if (bus.run) begin
                  r_ir    <= bus.imem_data;
                  r_state <= ST_EXEC1;
               end
            end
            ST_EXEC1: begin
               if (w_is_ldr || w_is_mul) begin
                  r_state <= ST_EXEC2;
               end else if (w_is_halt) begin
                  r_state  <= ST_HALT;
                  r_halted <= 1'b1;
               end else begin
                  r_pc    <= w_take_branch ? w_br_target : w_pc_inc;
                  r_state <= ST_FETCH;
               end
            end
            ST_EXEC2: begin
               if (w_is_mul) begin
                  r_state <= ST_EXEC3;
               end else begin
                  r_pc    <= w_pc_inc;
                  r_state <= ST_FETCH;
               end
            end
            ST_EXEC3: begin
               r_pc    <= w_pc_inc;
               r_state <= ST_FETCH;
            end
            ST_HALT: begin
               r_state <= ST_HALT;
            end
            default: begin
               r_state <= ST_FETCH;
            end
         endcase
      end
   end

   // Zero flag follows every ALU write-back, independent of sequencer state
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_zero <= 1'b0;
      end else if (bus.alu_wen) begin
         r_zero <= (bus.alu_d_out == 16'h0000);
      end
   end

   assign bus.imem_addr = r_pc;
   assign bus.inst      = r_ir[15:11];
   assign bus.rd_sel    = r_ir[10:8];
   assign bus.rs_sel    = r_ir[7:5];
   assign bus.state     = r_state;
   assign bus.mul_start = (r_state == ST_EXEC1) & w_is_mul;
   assign bus.zero      = r_zero;
   assign bus.halted    = r_halted;

endmodule
`default_nettype wire

// File: tb/tb_arm_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_arm_sequencer
// Description : Self-checking bench for arm_sequencer. A per-instruction
//               cycle-count model predicts all outputs every cycle; directed
//               programs pin known values, then random programs follow.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_arm_sequencer;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic [15:0] mem [256];

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model: pc, latched word, cycle index within instruction
   int          m_pc;
   logic [15:0] m_ir;
   int          m_step;
   bit          m_halted;
   bit          m_zero;

   arm_sequencer_if #(.PC_WIDTH(8)) bus_if ();

   arm_sequencer #(.PC_WIDTH(8), .RESET_PC(8'h00)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus_if)
   );

   always #5 clk = ~clk;

   // Combinational instruction memory
   assign bus_if.imem_data = mem[bus_if.imem_addr];

   function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endfunction

   function automatic int instr_cycles(input logic [4:0] op);
      if (op[4:1] == 4'b1101) return 4;
      if (op[4:1] == 4'b1110) return 3;
      return 2;
   endfunction

   function automatic int next_pc(input logic [15:0] ir, input int pc, input bit z);
      int off;
      off = int'($signed(ir[7:0]));
      if (ir[15:11] == 5'b00001 || (ir[15:11] == 5'b00010 && z))
         return (pc + off) & 255;
      return (pc + 1) & 255;
   endfunction

   // Advance the model by one clock edge using the inputs presented for it
   function automatic void model_update();
      bit z_old;
      z_old = m_zero;
      if (!reset_n) begin
         m_pc = 0; m_ir = '0; m_step = 0; m_halted = 0; m_zero = 0;
         return;
      end
      if (bus_if.alu_wen) m_zero = (bus_if.alu_d_out == 16'h0000);
      if (m_halted) return;
      if (m_step == 0) begin
         if (bus_if.run) begin
            m_ir   = mem[m_pc[7:0]];
            m_step = 1;
         end
      end else if (m_step == 1 && m_ir[15:11] == 5'b00011) begin
         m_halted = 1;
      end else if (m_step == instr_cycles(m_ir[15:11]) - 1) begin
         m_pc   = next_pc(m_ir, m_pc, z_old);
         m_step = 0;
      end else begin
         m_step++;
      end
   endfunction

   function automatic void compare_all();
      logic [3:0] exp_state;
      bit         exp_mul;
      exp_state = m_halted ? 4'b0000 : 4'(1 << m_step);
      exp_mul   = !m_halted && m_step == 1 && m_ir[15:12] == 4'b1101;
      check("state",     32'(bus_if.state),     32'(exp_state));
      check("imem_addr", 32'(bus_if.imem_addr), 32'(m_pc));
      check("inst",      32'(bus_if.inst),      32'(m_ir[15:11]));
      check("rd_sel",    32'(bus_if.rd_sel),    32'(m_ir[10:8]));
      check("rs_sel",    32'(bus_if.rs_sel),    32'(m_ir[7:5]));
      check("mul_start", 32'(bus_if.mul_start), 32'(exp_mul));
      check("zero",      32'(bus_if.zero),      32'(m_zero));
      check("halted",    32'(bus_if.halted),    32'(m_halted));
   endfunction

   task automatic tick(input logic rn, input logic r, input logic w, input logic [15:0] d);
      @(negedge clk);
      reset_n          = rn;
      bus_if.run       = r;
      bus_if.alu_wen   = w;
      bus_if.alu_d_out = d;
      @(posedge clk);
      model_update();
      #1;
      compare_all();
   endtask

   task automatic clear_mem();
      for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
   endtask

   task automatic do_reset();
      tick(1'b0, 1'b0, 1'b0, 16'h0);
   endtask

   task automatic run_n(input int n);
      for (int i = 0; i < n; i++) tick(1'b1, 1'b1, 1'b0, 16'h0);
   endtask

   initial begin
      logic [15:0] w;
      bus_if.run = 1'b0; bus_if.alu_wen = 1'b0; bus_if.alu_d_out = '0;
      m_pc = 0; m_ir = '0; m_step = 0; m_halted = 0; m_zero = 0;

      // ---- Straight-line program: add, nops, ldr, nop, mul, nop, halt
      clear_mem();
      mem[0] = 16'h8140;   // add rd=1 rs=2
      mem[3] = 16'hE100;   // ldr
      mem[5] = 16'hD220;   // mul
      mem[7] = 16'h1800;   // halt
      do_reset();
      do_reset();
      check("lit_reset_state", 32'(bus_if.state), 32'h1);
      check("lit_reset_pc", 32'(bus_if.imem_addr), 32'h0);
      run_n(1);
      check("lit_add_exec1", 32'(bus_if.state), 32'h2);
      check("lit_add_inst", 32'(bus_if.inst), 32'h10);
      check("lit_add_rd", 32'(bus_if.rd_sel), 32'h1);
      check("lit_add_rs", 32'(bus_if.rs_sel), 32'h2);
      run_n(1);
      check("lit_add_pc", 32'(bus_if.imem_addr), 32'h1);
      run_n(4);            // two nops -> pc 3
      run_n(2);            // ldr fetch, EXEC1
      check("lit_ldr_exec2", 32'(bus_if.state), 32'h4);
      check("lit_ldr_pc_hold", 32'(bus_if.imem_addr), 32'h3);
      run_n(1);
      check("lit_ldr_pc", 32'(bus_if.imem_addr), 32'h4);
      run_n(2);            // nop -> pc 5
      run_n(1);
      check("lit_mul_start", 32'(bus_if.mul_start), 32'h1);
      run_n(1);
      check("lit_mul_start_off", 32'(bus_if.mul_start), 32'h0);
      run_n(1);
      check("lit_mul_exec3", 32'(bus_if.state), 32'h8);
      run_n(1);
      check("lit_mul_pc", 32'(bus_if.imem_addr), 32'h6);
      run_n(4);            // nop, halt
      check("lit_halt_state", 32'(bus_if.state), 32'h0);
      for (int i = 0; i < 4; i++) tick(1'b1, 1'(i & 1), 1'b0, 16'h0);
      check("lit_halt_pc", 32'(bus_if.imem_addr), 32'h7);
      check("lit_halted", 32'(bus_if.halted), 32'h1);

      // ---- bz taken (zero set during EXEC1 of the preceding branch)
      clear_mem();
      mem[0]    = 16'h0810;  // b +0x10
      mem[8'h10] = 16'h10FC; // bz -4
      do_reset();
      run_n(1);
      tick(1'b1, 1'b1, 1'b1, 16'h0000);
      run_n(2);
      check("lit_bz_taken", 32'(bus_if.imem_addr), 32'h0C);
      // ---- bz not taken
      do_reset();
      run_n(1);
      tick(1'b1, 1'b1, 1'b1, 16'h0005);
      run_n(2);
      check("lit_bz_not_taken", 32'(bus_if.imem_addr), 32'h11);

      // ---- Branch wrap and run=0 hold
      clear_mem();
      mem[0]     = 16'h08FE; // b -2 -> 0xFE
      mem[8'hFE] = 16'h0805; // b +5 -> 0x03
      do_reset();
      run_n(2);
      check("lit_b_neg", 32'(bus_if.imem_addr), 32'hFE);
      run_n(2);
      check("lit_b_wrap", 32'(bus_if.imem_addr), 32'h03);
      for (int i = 0; i < 3; i++) tick(1'b1, 1'b0, 1'b0, 16'h0);
      check("lit_hold_state", 32'(bus_if.state), 32'h1);
      check("lit_hold_inst", 32'(bus_if.inst), 32'h01);

      // ---- Reset during EXEC2 of ldr clears zero and pc
      clear_mem();
      mem[0] = 16'hE100;
      do_reset();
      mem[1] = 16'h0000;
      run_n(2);            // move to pc 1 via... nothing: ldr needs 3 cycles
      tick(1'b1, 1'b1, 1'b0, 16'h0);  // completes ldr -> pc 1
      run_n(2);            // nop -> pc 2 (mem[2]=0 nop)
      mem[2] = 16'hE100;
      run_n(1);            // ldr fetch at pc 2
      tick(1'b1, 1'b1, 1'b1, 16'h0000);
      check("lit_ldr_exec2_b", 32'(bus_if.state), 32'h4);
      check("lit_zero_set", 32'(bus_if.zero), 32'h1);
      tick(1'b0, 1'b1, 1'b0, 16'h0);
      check("lit_rst_state", 32'(bus_if.state), 32'h1);
      check("lit_rst_pc", 32'(bus_if.imem_addr), 32'h0);
      check("lit_rst_zero", 32'(bus_if.zero), 32'h0);

      // ---- Random programs with random run / write-back / reset
      for (int i = 0; i < 256; i++) begin
         w = 16'($urandom);
         case ($urandom_range(0, 7))
            0: w[15:11] = 5'b00001;
            1: w[15:11] = 5'b00010;
            2: w[15:11] = 5'b11100;
            3: w[15:11] = 5'b11010;
            default: ;
         endcase
         if (w[15:11] == 5'b00011 && $urandom_range(0, 3) != 0) w[15:11] = 5'b00000;
         mem[i] = w;
      end
      do_reset();
      for (int i = 0; i < 4000; i++) begin
         tick(1'($urandom_range(0, 63) != 0),
              1'($urandom_range(0, 4) != 0),
              1'($urandom_range(0, 1)),
              ($urandom_range(0, 3) == 0) ? 16'h0000 : 16'($urandom));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
